// File: rtl/data_cache_controller_pkg.sv
// Shared sizing defaults and FSM state type for the direct-mapped write-through data cache.
package data_cache_controller_pkg;

  localparam int unsigned DCC_WORD_SIZE  = 32;
  localparam int unsigned DCC_BLOCK_SIZE = 4;
  localparam int unsigned DCC_NUM_LINES  = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL_ADDR,
    FILL_WAIT,
    WRITE,
    RESP
  } dcc_state_e;

endpackage

// File: rtl/data_cache_controller_cache_line_array.sv
// Line storage: NUM_LINES x {valid, tag, BLOCK_SIZE words}. Async read, block fill, single-word write.
module cache_line_array #(
  parameter  int unsigned WORD_SIZE  = 32,
  parameter  int unsigned BLOCK_SIZE = 4,
  parameter  int unsigned NUM_LINES  = 8,
  localparam int unsigned OFF_BITS   = $clog2(BLOCK_SIZE),
  localparam int unsigned IDX_BITS   = $clog2(NUM_LINES),
  localparam int unsigned TAG_BITS   = WORD_SIZE - OFF_BITS - IDX_BITS
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [IDX_BITS-1:0]                  rd_idx_i,
  output logic                                 rd_valid_o,
  output logic [TAG_BITS-1:0]                  rd_tag_o,
  output logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] rd_block_o,
  input  logic                                 fill_en_i,
  input  logic [IDX_BITS-1:0]                  fill_idx_i,
  input  logic [TAG_BITS-1:0]                  fill_tag_i,
  input  logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] fill_block_i,
  input  logic                                 wr_en_i,
  input  logic [IDX_BITS-1:0]                  wr_idx_i,
  input  logic [OFF_BITS-1:0]                  wr_off_i,
  input  logic [WORD_SIZE-1:0]                 wr_data_i
);

  logic [NUM_LINES-1:0]                 valid_q;
  logic [TAG_BITS-1:0]                  tag_q  [NUM_LINES];
  logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] data_q [NUM_LINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
    end
  end

  // Tags and data are deliberately left out of reset; only valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_block_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_block_o = data_q[rd_idx_i];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller in front of data_memory.
module data_cache_controller
  import data_cache_controller_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = DCC_WORD_SIZE,
  parameter int unsigned BLOCK_SIZE = DCC_BLOCK_SIZE,
  parameter int unsigned NUM_LINES  = DCC_NUM_LINES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cpu_req,
  input  logic                            cpu_we,
  input  logic [WORD_SIZE-1:0]            cpu_addr,
  input  logic [WORD_SIZE-1:0]            cpu_wdata,
  output logic [WORD_SIZE-1:0]            cpu_rdata,
  output logic                            cpu_ready,
  output logic [WORD_SIZE-1:0]            mem_ptr,
  output logic [WORD_SIZE-1:0]            mem_val,
  output logic                            mem_write_enable,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_out_block
);

  localparam int unsigned OFF_BITS = $clog2(BLOCK_SIZE);
  localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS = WORD_SIZE - OFF_BITS - IDX_BITS;

  dcc_state_e state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic [WORD_SIZE-1:0] ptr_q, ptr_d;
  logic [WORD_SIZE-1:0] val_q, val_d;
  logic                 mwe_q, mwe_d;

  logic [WORD_SIZE-1:0]                 lk_addr;
  logic [OFF_BITS-1:0]                  lk_off;
  logic [IDX_BITS-1:0]                  lk_idx;
  logic [TAG_BITS-1:0]                  lk_tag;
  logic                                 lk_valid;
  logic [TAG_BITS-1:0]                  line_tag;
  logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] line_block;
  logic [BLOCK_SIZE-1:0][WORD_SIZE-1:0] fill_block;
  logic                                 hit;
  logic                                 fill_en;
  logic                                 wr_en;

  // In IDLE the lookup uses the live request so a load hit answers in one cycle;
  // afterwards the latched address drives every lookup, fill and write.
  assign lk_addr    = (state_q == IDLE) ? cpu_addr : addr_q;
  assign lk_off     = lk_addr[OFF_BITS-1:0];
  assign lk_idx     = lk_addr[OFF_BITS +: IDX_BITS];
  assign lk_tag     = lk_addr[WORD_SIZE-1 -: TAG_BITS];
  assign hit        = lk_valid && (line_tag == lk_tag);
  assign fill_block = mem_out_block;

  cache_line_array #(
    .WORD_SIZE (WORD_SIZE),
    .BLOCK_SIZE(BLOCK_SIZE),
    .NUM_LINES (NUM_LINES)
  ) u_lines (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_idx_i    (lk_idx),
    .rd_valid_o  (lk_valid),
    .rd_tag_o    (line_tag),
    .rd_block_o  (line_block),
    .fill_en_i   (fill_en),
    .fill_idx_i  (lk_idx),
    .fill_tag_i  (lk_tag),
    .fill_block_i(fill_block),
    .wr_en_i     (wr_en),
    .wr_idx_i    (lk_idx),
    .wr_off_i    (lk_off),
    .wr_data_i   (wdata_q)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ptr_d   = ptr_q;
    val_d   = val_q;
    ready_d = 1'b0;
    mwe_d   = 1'b0;
    fill_en = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          if (cpu_we) begin
            state_d = WRITE;
            ptr_d   = cpu_addr;
            val_d   = cpu_wdata;
            mwe_d   = 1'b1;
          end else if (hit) begin
            state_d = RESP;
            rdata_d = line_block[lk_off];
            ready_d = 1'b1;
          end else begin
            state_d = FILL_ADDR;
            ptr_d   = {cpu_addr[WORD_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
          end
        end
      end
      FILL_ADDR: state_d = FILL_WAIT;
      FILL_WAIT: begin
        fill_en = 1'b1;
        rdata_d = fill_block[lk_off];
        ready_d = 1'b1;
        state_d = RESP;
      end
      WRITE: begin
        wr_en   = hit;
        ready_d = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      ptr_q   <= '0;
      val_q   <= '0;
      mwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      ptr_q   <= ptr_d;
      val_q   <= val_d;
      mwe_q   <= mwe_d;
    end
  end

  assign cpu_rdata        = rdata_q;
  assign cpu_ready        = ready_q;
  assign mem_ptr          = ptr_q;
  assign mem_val          = val_q;
  assign mem_write_enable = mwe_q;

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench: data_cache_controller in front of a registered-read data_memory model.
module tb_data_cache_controller;

  logic         clk;
  logic         rst_n;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic [31:0]  mem_ptr;
  logic [31:0]  mem_val;
  logic         mem_write_enable;
  logic [127:0] mem_out_block;

  logic [31:0]  mem [256];
  logic         mem_init;
  logic [7:0]   base;

  int errors = 0;
  int checks = 0;

  data_cache_controller #(
    .WORD_SIZE (32),
    .BLOCK_SIZE(4),
    .NUM_LINES (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_req         (cpu_req),
    .cpu_we          (cpu_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_ready       (cpu_ready),
    .mem_ptr         (mem_ptr),
    .mem_val         (mem_val),
    .mem_write_enable(mem_write_enable),
    .mem_out_block   (mem_out_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory: write on posedge when enabled, block read registered from ptr.
  assign base = {mem_ptr[7:2], 2'b00};
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + i;
    end else if (mem_write_enable) begin
      mem[mem_ptr[7:0]] <= mem_val;
    end
    mem_out_block <= {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic [31:0] ptr1,
                        output logic [31:0] ptr2, output logic [31:0] val1, output int wecnt);
    logic seen;
    seen  = 1'b0;
    lat   = 0;
    wecnt = 0;
    rdata = 'x;
    ptr1  = 'x;
    ptr2  = 'x;
    val1  = 'x;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) begin ptr1 = mem_ptr; val1 = mem_val; end
      if (lat == 2) ptr2 = mem_ptr;
      if (mem_write_enable) wecnt++;
      if (cpu_ready) begin
        seen  = 1'b1;
        rdata = cpu_rdata;
      end
    end
    if (!seen) chk("ready_timeout", 32'(seen), 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("ready_single_pulse", 32'(cpu_ready), 32'd0);
  endtask

  int          lat, wecnt, pulses;
  logic [31:0] rd, p1, p2, v1;
  logic [31:0] seq_data [3];
  int          seq_cyc  [3];

  initial begin
    rst_n = 1'b0; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_ready", 32'(cpu_ready), 32'h0);
    chk("rst_ptr", mem_ptr, 32'h0);
    chk("rst_val", mem_val, 32'h0);
    chk("rst_we", 32'(mem_write_enable), 32'h0);
    rst_n = 1'b1; mem_init = 1'b0;

    // 1: store addr 3 val 8
    do_req(1'b1, 32'd3, 32'd8, lat, rd, p1, p2, v1, wecnt);
    chk("st3_lat", 32'(lat), 32'd2);
    chk("st3_wecnt", 32'(wecnt), 32'd1);
    chk("st3_ptr", p1, 32'd3);
    chk("st3_val", v1, 32'd8);
    chk("st3_mem", mem[3], 32'd8);
    chk("st3_rdata_kept", rd, 32'h0);

    // 2: load 3 miss then hit
    do_req(1'b0, 32'd3, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("ld3_miss_lat", 32'(lat), 32'd3);
    chk("ld3_miss_ptr1", p1, 32'd0);
    chk("ld3_miss_ptr2", p2, 32'd0);
    chk("ld3_miss_we", 32'(wecnt), 32'd0);
    chk("ld3_miss_data", rd, 32'd8);
    do_req(1'b0, 32'd3, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("ld3_hit_lat", 32'(lat), 32'd1);
    chk("ld3_hit_data", rd, 32'd8);
    chk("ld3_hit_we", 32'(wecnt), 32'd0);

    // 3: store hit updates cache; store miss does not allocate
    do_req(1'b1, 32'd1, 32'h55, lat, rd, p1, p2, v1, wecnt);
    chk("st1_lat", 32'(lat), 32'd2);
    chk("st1_mem", mem[1], 32'h55);
    chk("st1_rdata_kept", rd, 32'd8);
    do_req(1'b0, 32'd1, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("ld1_hit_lat", 32'(lat), 32'd1);
    chk("ld1_hit_data", rd, 32'h55);
    do_req(1'b1, 32'd40, 32'h77, lat, rd, p1, p2, v1, wecnt);
    chk("st40_lat", 32'(lat), 32'd2);
    chk("st40_mem", mem[40], 32'h77);
    do_req(1'b0, 32'd40, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("ld40_miss_lat", 32'(lat), 32'd3);
    chk("ld40_ptr", p1, 32'd40);
    chk("ld40_data", rd, 32'h77);

    // 4: conflicts on index 0 (67 first evicts the resident tag-0 line)
    do_req(1'b0, 32'd67, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("ld67_lat", 32'(lat), 32'd3);
    chk("ld67_ptr", p1, 32'd64);
    chk("ld67_data", rd, 32'h1043);
    do_req(1'b0, 32'd3, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("cf3a_lat", 32'(lat), 32'd3);
    chk("cf3a_ptr", p1, 32'd0);
    chk("cf3a_data", rd, 32'd8);
    do_req(1'b0, 32'd35, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("cf35_lat", 32'(lat), 32'd3);
    chk("cf35_ptr", p1, 32'd32);
    chk("cf35_data", rd, 32'h1023);
    do_req(1'b0, 32'd3, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("cf3b_lat", 32'(lat), 32'd3);
    chk("cf3b_ptr", p1, 32'd0);
    chk("cf3b_data", rd, 32'd8);

    // 5: reset during FILL_WAIT, then during WRITE before its commit edge
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd35;
    tick(); tick();
    chk("fw_ptr_before", mem_ptr, 32'd32);
    #2 rst_n = 1'b0;
    #1;
    chk("fw_rst_rdata", cpu_rdata, 32'h0);
    chk("fw_rst_ptr", mem_ptr, 32'h0);
    chk("fw_rst_ready", 32'(cpu_ready), 32'h0);
    chk("fw_rst_we", 32'(mem_write_enable), 32'h0);
    cpu_req = 1'b0;
    tick();
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'h99;
    tick();
    chk("wr_we_high", 32'(mem_write_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("wr_rst_we", 32'(mem_write_enable), 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    chk("wr_abort_mem", mem[5], 32'h1005);
    rst_n = 1'b1;
    do_req(1'b0, 32'd3, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", rd, 32'd8);

    // 6: back-to-back loads with cpu_req held high
    do_req(1'b0, 32'd67, 32'd0, lat, rd, p1, p2, v1, wecnt);
    chk("evict_lat", 32'(lat), 32'd3);
    pulses = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (cpu_ready) begin
        if (pulses < 3) begin
          seq_data[pulses] = cpu_rdata;
          seq_cyc[pulses]  = c;
        end
        pulses++;
        if (pulses >= 3) cpu_req = 1'b0;
        else cpu_addr = 32'(pulses);
      end
    end
    chk("seq_pulses", 32'(pulses), 32'd3);
    chk("seq0_data", seq_data[0], 32'h1000);
    chk("seq1_data", seq_data[1], 32'h55);
    chk("seq2_data", seq_data[2], 32'h1002);
    chk("seq0_cycle", 32'(seq_cyc[0]), 32'd3);
    chk("seq1_cycle", 32'(seq_cyc[1]), 32'd5);
    chk("seq2_cycle", 32'(seq_cyc[2]), 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
